conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_addr_gen.sv | 116 +++++++++++
 rtl/conv_seq_ctrl.sv | 98 +++++++++
 tb/tb_conv_seq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared state encoding and geometry helpers for the convolution sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_MAC   = 3'd2,
        ST_STORE = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    localparam int CNT_W = 16;

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int taps(input int k);
        return k * k;
    endfunction

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width that holds every address without wrap, never narrower than the port.
    function automatic int full_addr_w(input int img_w, input int img_h, input int k,
                                       input int n_ch, input int addr_w);
        int span;
        int need;
        span = img_w * img_h;
        if (n_ch * k * k > span) span = n_ch * k * k;
        if (n_ch * out_dim(img_w, k) * out_dim(img_h, k) > span)
            span = n_ch * out_dim(img_w, k) * out_dim(img_h, k);
        need = $clog2(span + 1);
        return (need > addr_w) ? need : addr_w;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Pixel/tap/channel counters and registered read/write address generation.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int N_CH   = 4,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      tap_adv,
    input  logic                      pix_adv,
    output logic [ADDR_W-1:0]         in_addr,
    output logic [ADDR_W-1:0]         w_addr,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [sel_w(N_CH)-1:0]    ch_sel,
    output logic                      last_tap,
    output logic                      last_pix
);
    localparam int OW   = out_dim(IMG_W, K);
    localparam int OH   = out_dim(IMG_H, K);
    localparam int TAPS = taps(K);
    localparam int CH_W = sel_w(N_CH);
    localparam int FW   = full_addr_w(IMG_W, IMG_H, K, N_CH, ADDR_W);

    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d, ky_q, ky_d, kx_q, kx_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d, w_addr_q, w_addr_d, out_addr_q, out_addr_d;
    logic [FW-1:0]     in_full, w_full, out_full;
    logic              kx_max, ky_max, col_max, row_max, ch_max;

    assign kx_max  = (kx_q == CNT_W'(K - 1));
    assign ky_max  = (ky_q == CNT_W'(K - 1));
    assign col_max = (col_q == CNT_W'(OW - 1));
    assign row_max = (row_q == CNT_W'(OH - 1));
    assign ch_max  = (ch_q == CH_W'(N_CH - 1));

    assign last_tap = ky_max && kx_max;
    assign last_pix = ch_max && row_max && col_max;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        ky_d  = ky_q;
        kx_d  = kx_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
            ch_d  = '0;
            ky_d  = '0;
            kx_d  = '0;
        end else begin
            if (tap_adv) begin
                if (kx_max) begin
                    kx_d = '0;
                    ky_d = ky_max ? '0 : ky_q + CNT_W'(1);
                end else begin
                    kx_d = kx_q + CNT_W'(1);
                end
            end
            if (pix_adv) begin
                if (col_max) begin
                    col_d = '0;
                    if (row_max) begin
                        row_d = '0;
                        ch_d  = ch_max ? '0 : ch_q + CH_W'(1);
                    end else begin
                        row_d = row_q + CNT_W'(1);
                    end
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end
        end
        // Addresses are formed from the next counter values so the registered
        // outputs line up with the state/strobes of the same cycle.
        in_full  = (FW'(row_d) + FW'(ky_d)) * FW'(IMG_W) + FW'(col_d) + FW'(kx_d);
        w_full   = FW'(ch_d) * FW'(TAPS) + FW'(ky_d) * FW'(K) + FW'(kx_d);
        out_full = FW'(ch_d) * FW'(OW * OH) + FW'(row_d) * FW'(OW) + FW'(col_d);
        in_addr_d  = in_full[ADDR_W-1:0];
        w_addr_d   = w_full[ADDR_W-1:0];
        out_addr_d = out_full[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            out_addr_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            ch_q       <= ch_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            in_addr_q  <= in_addr_d;
            w_addr_q   <= w_addr_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign in_addr  = in_addr_q;
    assign w_addr   = w_addr_q;
    assign out_addr = out_addr_q;
    assign ch_sel   = ch_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution pass sequencer: CLR -> MAC(K*K taps) -> STORE per output pixel, then FIN.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int N_CH   = 4,
    parameter int ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   abort,
    output logic [ADDR_W-1:0]      in_addr,
    output logic [ADDR_W-1:0]      w_addr,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [sel_w(N_CH)-1:0] ch_sel,
    output logic                   acc_clr,
    output logic                   acc_en,
    output logic                   store,
    output logic                   busy,
    output logic                   done
);
    state_e state_q, state_d;
    logic   busy_q, busy_d, done_q, done_d;
    logic   cnt_clr, tap_adv, pix_adv, last_tap, last_pix;

    conv_addr_gen #(
        .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .N_CH(N_CH), .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .tap_adv  (tap_adv),
        .pix_adv  (pix_adv),
        .in_addr  (in_addr),
        .w_addr   (w_addr),
        .out_addr (out_addr),
        .ch_sel   (ch_sel),
        .last_tap (last_tap),
        .last_pix (last_pix)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        tap_adv = 1'b0;
        pix_adv = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        store   = 1'b0;
        // Abort outranks stall; a stalled cycle issues no strobes and moves nothing.
        if (state_q != ST_IDLE && abort) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else if (!stall) begin
            case (state_q)
                ST_IDLE:  if (start && !abort) state_d = ST_CLR;
                ST_CLR: begin
                    acc_clr = 1'b1;
                    state_d = ST_MAC;
                end
                ST_MAC: begin
                    acc_en  = 1'b1;
                    tap_adv = 1'b1;
                    if (last_tap) state_d = ST_STORE;
                end
                ST_STORE: begin
                    store   = 1'b1;
                    pix_adv = 1'b1;
                    state_d = last_pix ? ST_FIN : ST_CLR;
                end
                ST_FIN:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with K=3, 5x5 image, 2 channels.
module tb_conv_seq_ctrl;
    logic        clk, rst_n, start, stall, abort;
    logic [15:0] in_addr, w_addr, out_addr;
    logic [0:0]  ch_sel;
    logic        acc_clr, acc_en, store, busy, done;

    int n_vec = 0;
    int n_err = 0;
    int n_store = 0, n_mac = 0, n_done = 0;
    int s_store, s_mac, s_done;
    int c, dc;
    int exp_in [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

    conv_seq_ctrl #(.K(3), .IMG_W(5), .IMG_H(5), .N_CH(2), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
        .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr), .ch_sel(ch_sel),
        .acc_clr(acc_clr), .acc_en(acc_en), .store(store), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (store)  n_store <= n_store + 1;
            if (acc_en) n_mac   <= n_mac + 1;
            if (done)   n_done  <= n_done + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap;
        s_store = n_store;
        s_mac   = n_mac;
        s_done  = n_done;
    endtask

    // One pass from a start pulse; optional 4-cycle stall at cycle stall_at and
    // optional start pokes while busy. dc = cycle (start edge = 1) showing done.
    task automatic run_pass(input int stall_at, input bit poke, output int dcyc);
        int cc;
        logic [15:0] frz;
        dcyc = 0;
        frz = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        cc = 1;
        while (dcyc == 0 && cc < 1000) begin
            if (cc == stall_at) begin
                stall = 1'b1;
                frz = in_addr;
            end
            if (cc == stall_at + 4) stall = 1'b0;
            if (poke && (cc % 50 == 0)) start = 1'b1;
            #1;
            if (stall) begin
                chk("stall_acc_en", 32'(acc_en), 0);
                chk("stall_in_addr", 32'(in_addr), 32'(frz));
            end
            if (stall_at > 0 && cc == stall_at + 4) begin
                chk("resume_acc_en", 32'(acc_en), 1);
                chk("resume_in_addr", 32'(in_addr), 32'(frz));
            end
            if (done) dcyc = cc;
            else begin
                tick;
                start = 1'b0;
                cc++;
            end
        end
        if (dcyc == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_addr", 32'(in_addr), 0);
        chk("rst_w_addr", 32'(w_addr), 0);
        chk("rst_out_addr", 32'(out_addr), 0);
        chk("rst_ch_sel", 32'(ch_sel), 0);
        chk("rst_strobes", {29'd0, acc_clr, acc_en, store}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("idle_busy", 32'(busy), 0);

        // Full pass with address tracing of first and last pixel.
        snap;
        start = 1'b1;
        tick;
        start = 1'b0;
        c = 1;
        chk("clr_acc_clr", 32'(acc_clr), 1);
        chk("clr_busy", 32'(busy), 1);
        chk("clr_acc_en", 32'(acc_en), 0);
        while (c < 199 && !done) begin
            tick;
            c++;
            if (c >= 2 && c <= 10) begin
                chk("p0_in_addr", 32'(in_addr), 32'(exp_in[c-2]));
                chk("p0_w_addr", 32'(w_addr), 32'(c - 2));
                chk("p0_acc_en", 32'(acc_en), 1);
            end
            if (c == 11) begin
                chk("p0_store", 32'(store), 1);
                chk("p0_out_addr", 32'(out_addr), 0);
            end
            if (c >= 189 && c <= 197) begin
                chk("last_w_addr", 32'(w_addr), 32'(9 + c - 189));
                chk("last_ch_sel", 32'(ch_sel), 1);
            end
            if (c == 198) begin
                chk("last_store", 32'(store), 1);
                chk("last_out_addr", 32'(out_addr), 17);
            end
        end
        chk("done_cycle", 32'(c), 199);
        chk("done_high", 32'(done), 1);
        tick;
        chk("post_busy", 32'(busy), 0);
        chk("post_done", 32'(done), 0);
        chk("store_count", 32'(n_store - s_store), 18);
        chk("mac_count", 32'(n_mac - s_mac), 162);
        chk("done_count", 32'(n_done - s_done), 1);

        // Stall held for 4 cycles mid-MAC.
        snap;
        run_pass(5, 1'b0, dc);
        chk("stall_done_cycle", 32'(dc), 203);
        chk("stall_mac_count", 32'(n_mac - s_mac), 162);
        tick;

        // Abort in the STORE of pixel 3.
        snap;
        start = 1'b1;
        tick;
        start = 1'b0;
        c = 1;
        while (c < 44) begin
            tick;
            c++;
        end
        chk("abort_at_store", 32'(store), 1);
        chk("abort_at_out_addr", 32'(out_addr), 3);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_addr", 32'(in_addr), 0);
        chk("abort_w_addr", 32'(w_addr), 0);
        chk("abort_out_addr", 32'(out_addr), 0);
        chk("abort_ch_sel", 32'(ch_sel), 0);
        repeat (20) tick;
        chk("abort_no_done", 32'(n_done - s_done), 0);

        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);
        chk("start_abort_clr", 32'(acc_clr), 0);

        start = 1'b1;
        tick;
        start = 1'b0;
        c = 1;
        repeat (10) begin
            tick;
            c++;
        end
        chk("rerun_store", 32'(store), 1);
        chk("rerun_out_addr", 32'(out_addr), 0);
        while (!done && c < 400) begin
            tick;
            c++;
        end
        chk("rerun_done_cycle", 32'(c), 199);
        tick;

        // Reset mid-MAC, then a pass with start pokes while busy.
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        chk("pre_rst_in_addr", 32'(in_addr), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_acc_en", 32'(acc_en), 0);
        chk("midrst_in_addr", 32'(in_addr), 0);
        chk("midrst_w_addr", 32'(w_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick;
        chk("postrst_idle", 32'(busy), 0);
        snap;
        run_pass(0, 1'b1, dc);
        chk("poke_done_cycle", 32'(dc), 199);
        repeat (60) tick;
        chk("poke_done_count", 32'(n_done - s_done), 1);
        chk("poke_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
